// File: rtl/lmt_writer_pkg.sv
// Shared RATA constants for the LMT writer and the monitor that drives it.
//   - FSM state encodings (IDLE / WRITE)
//   - default byte address of the first LMT word
//   - number of 16-bit words in one LMT record
//   - helper for word byte addresses
package lmt_writer_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_WRITE = 1'b1;

    localparam logic [15:0] LMT_BASE_DFLT = 16'h0040;

    // Four timestamp words plus one update-count word.
    localparam int unsigned LMT_WORDS    = 5;
    localparam logic [2:0]  LMT_LAST_IDX = 3'(LMT_WORDS - 1);

    // Words are 16 bits wide, so consecutive words sit 2 bytes apart.
    function automatic logic [15:0] lmt_word_addr(input logic [15:0] base,
                                                  input logic [2:0]  idx);
        return base + {12'd0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/lmt_writer_if.sv
// Dedicated LMT memory write port.
//   lmt_wr    : word write request, held until acked (master -> slave)
//   lmt_addr  : byte address of the current word      (master -> slave)
//   lmt_wdata : data of the current word              (master -> slave)
//   lmt_ack   : memory accepted the word this cycle   (slave -> master)
interface lmt_writer_if;

    logic        lmt_wr;
    logic        lmt_ack;
    logic [15:0] lmt_addr;
    logic [15:0] lmt_wdata;

    modport master (output lmt_wr, output lmt_addr, output lmt_wdata, input lmt_ack);
    modport slave  (input lmt_wr, input lmt_addr, input lmt_wdata, output lmt_ack);

endinterface

// File: rtl/lmt_timer.sv
// Free-running 64-bit timestamp with a clock prescaler.
//   clk       : system clock, posedge
//   reset     : synchronous active-high reset, loads RESET_VALUE
//   timestamp : increments once every TICK_DIV cycles, wraps modulo 2^64
module lmt_timer #(
    parameter logic [15:0] TICK_DIV    = 16'd1,
    parameter logic [63:0] RESET_VALUE = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] timestamp
);

    // TICK_DIV of 0 is treated like 1.
    localparam logic [15:0] PRE_LAST = (TICK_DIV == 16'd0) ? 16'd0 : TICK_DIV - 16'd1;

    logic [15:0] pre_q;
    logic [63:0] ts_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
            ts_q  <= RESET_VALUE;
        end else if (pre_q >= PRE_LAST) begin
            pre_q <= '0;
            ts_q  <= ts_q + 64'd1;
        end else begin
            pre_q <= pre_q + 16'd1;
        end
    end

    assign timestamp = ts_q;

endmodule

// File: rtl/lmt_writer.sv
// LMT record writer. On each rising edge of upLMT it snapshots the timestamp
// and writes a 5-word record (timestamp LSW..MSW, then update count) over the
// dedicated lmt_* port, one word per ack.
//   clk, reset : system clock, synchronous active-high reset
//   upLMT      : update request level from the RATA monitor
//   mem        : lmt_wr/lmt_addr/lmt_wdata out, lmt_ack in
//   busy       : high while a record is in progress
//   done       : one-cycle pulse after the last word is acked
//   err        : sticky ack-timeout flag
//   timestamp  : live timestamp counter
module lmt_writer
    import lmt_writer_pkg::*;
#(
    parameter logic [15:0] LMT_BASE    = LMT_BASE_DFLT,
    parameter logic [15:0] TICK_DIV    = 16'd1,
    parameter logic [15:0] ACK_TIMEOUT = 16'd64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                upLMT,
    lmt_writer_if.master        mem,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [63:0]         timestamp
);

    logic        state_q, state_d;
    logic [63:0] snap_q, snap_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [15:0] tmo_q, tmo_d;
    logic        uplmt_q;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        trigger;
    logic        rec_end;
    logic [15:0] word;

    lmt_timer #(
        .TICK_DIV    (TICK_DIV),
        .RESET_VALUE (64'd0)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .timestamp (timestamp)
    );

    assign trigger = upLMT & ~uplmt_q;

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        err_d   = err_q;
        rec_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // lmt_ack is deliberately ignored here.
                if (trigger) begin
                    state_d = ST_WRITE;
                    snap_d  = timestamp;
                    idx_d   = '0;
                    tmo_d   = '0;
                end
            end
            ST_WRITE: begin
                if (trigger) begin
                    pend_d = 1'b1;
                end
                if (mem.lmt_ack) begin
                    tmo_d = '0;
                    if (idx_q == LMT_LAST_IDX) begin
                        cnt_d   = cnt_q + 16'd1;
                        done_d  = 1'b1;
                        rec_end = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (tmo_q + 16'd1 >= ACK_TIMEOUT) begin
                    // Abort: count is left alone and done stays low.
                    err_d   = 1'b1;
                    rec_end = 1'b1;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
                // A pending request (including one arriving this very cycle)
                // starts the next record without passing through IDLE.
                if (rec_end) begin
                    if (pend_d) begin
                        snap_d = timestamp;
                        idx_d  = '0;
                        tmo_d  = '0;
                        pend_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            tmo_q   <= '0;
            uplmt_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            tmo_q   <= tmo_d;
            uplmt_q <= upLMT;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // The count word shows the value the count will have once this record lands.
    always_comb begin
        case (idx_q)
            3'd0:    word = snap_q[15:0];
            3'd1:    word = snap_q[31:16];
            3'd2:    word = snap_q[47:32];
            3'd3:    word = snap_q[63:48];
            default: word = cnt_q + 16'd1;
        endcase
    end

    assign mem.lmt_wr    = (state_q == ST_WRITE);
    assign mem.lmt_addr  = (state_q == ST_WRITE) ? lmt_word_addr(LMT_BASE, idx_q) : 16'd0;
    assign mem.lmt_wdata = (state_q == ST_WRITE) ? word : 16'd0;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_lmt_writer.sv
module tb_lmt_writer;

    localparam int          ACK_TO   = 64;
    localparam logic [63:0] TMR_INIT = 64'hFFFF_FFFF_FFFF_FFFD;

    logic        clk = 1'b0;
    logic        reset;
    logic        upLMT;
    logic        ack;
    logic        busy, done, err;
    logic [63:0] timestamp;
    logic        tmr_reset;
    logic [63:0] tmr_ts;

    lmt_writer_if mem_if ();
    assign mem_if.lmt_ack = ack;

    lmt_writer dut (
        .clk       (clk),
        .reset     (reset),
        .upLMT     (upLMT),
        .mem       (mem_if),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .timestamp (timestamp)
    );

    lmt_timer #(
        .TICK_DIV    (16'd4),
        .RESET_VALUE (TMR_INIT)
    ) u_tmr (
        .clk       (clk),
        .reset     (tmr_reset),
        .timestamp (tmr_ts)
    );

    always #5 clk = ~clk;

    // Behavioural reference: a record is an array of five words built at
    // snapshot time, walked one position per accepted word.
    logic [63:0] m_ts;
    logic        m_act;
    int          m_pos;
    int          m_wait;
    logic [15:0] m_cnt;
    logic        m_pend;
    logic        m_prev;
    logic        m_done;
    logic        m_err;
    logic [63:0] m_snap;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_busy = 0;

    logic [15:0] log_addr[$];
    logic [15:0] log_data[$];
    int          log_cyc[$];
    int          done_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_update();
        logic        trig;
        logic        fin;
        logic [63:0] t0;
        if (reset) begin
            m_ts = '0; m_act = 1'b0; m_pos = 0; m_wait = 0; m_cnt = '0;
            m_pend = 1'b0; m_prev = 1'b0; m_done = 1'b0; m_err = 1'b0; m_snap = '0;
            return;
        end
        trig   = upLMT && !m_prev;
        m_prev = upLMT;
        m_done = 1'b0;
        t0     = m_ts;
        m_ts   = m_ts + 64'd1;
        fin    = 1'b0;
        if (!m_act) begin
            if (trig) begin
                m_act = 1'b1; m_snap = t0; m_pos = 0; m_wait = 0;
            end
        end else begin
            if (trig) m_pend = 1'b1;
            if (ack) begin
                m_wait = 0;
                if (m_pos == 4) begin
                    m_cnt  = m_cnt + 16'd1;
                    m_done = 1'b1;
                    fin    = 1'b1;
                end else begin
                    m_pos++;
                end
            end else begin
                m_wait++;
                if (m_wait == ACK_TO) begin
                    m_err = 1'b1;
                    fin   = 1'b1;
                end
            end
            if (fin) begin
                if (m_pend) begin
                    m_pend = 1'b0; m_snap = t0; m_pos = 0; m_wait = 0;
                end else begin
                    m_act = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle_check();
        logic [15:0] e_addr, e_data;
        e_addr = 16'd0;
        e_data = 16'd0;
        if (m_act) begin
            e_addr = 16'h0040 + 16'(2 * m_pos);
            e_data = (m_pos < 4) ? m_snap[16*m_pos +: 16] : 16'(m_cnt + 16'd1);
        end
        chk("wr",    mem_if.lmt_wr,    m_act);
        chk("addr",  mem_if.lmt_addr,  e_addr);
        chk("wdata", mem_if.lmt_wdata, e_data);
        chk("busy",  busy,             m_act);
        chk("done",  done,             m_done);
        chk("err",   err,              m_err);
        chk("ts",    timestamp,        m_ts);
        if (mem_if.lmt_wr && ack) begin
            log_addr.push_back(mem_if.lmt_addr);
            log_data.push_back(mem_if.lmt_wdata);
            log_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (busy) n_busy++;
    endtask

    task automatic step();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        model_update();
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; upLMT = 1'b0; ack = 1'b0;
        step();
        reset = 1'b0;
    endtask

    int          b0, d0, nb0, mode;
    logic [63:0] s1, s2;
    logic [15:0] exp_addr[5];
    logic [15:0] exp_data[5];

    initial begin
        reset = 1'b1; upLMT = 1'b0; ack = 1'b0; tmr_reset = 1'b1;
        @(posedge clk);
        model_update();
        #1;
        reset = 1'b0;

        // Reset state
        do_reset();
        chk("rst_ts",   timestamp, 64'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr",   mem_if.lmt_wr, 1'b0);
        chk("rst_err",  err, 1'b0);
        step();

        // Single record at timestamp 0x10, ack always high
        do_reset();
        ack = 1'b1;
        for (int k = 0; k < 40 && m_ts != 64'h10; k++) step();
        chk("ts_reach_10", timestamp, 64'h10);
        upLMT = 1'b1; step(); upLMT = 1'b0;
        b0 = log_addr.size(); d0 = done_cyc.size(); nb0 = n_busy;
        repeat (8) step();
        exp_addr = '{16'h0040, 16'h0042, 16'h0044, 16'h0046, 16'h0048};
        exp_data = '{16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
        chk("rec1_words", log_addr.size() - b0, 5);
        if (log_addr.size() - b0 == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("rec1_addr", log_addr[b0+i], exp_addr[i]);
                chk("rec1_data", log_data[b0+i], exp_data[i]);
            end
        end
        chk("rec1_busy", n_busy - nb0, 5);
        chk("rec1_done_n", done_cyc.size() - d0, 1);
        if (done_cyc.size() - d0 == 1 && log_cyc.size() - b0 == 5)
            chk("rec1_done_at", done_cyc[d0], log_cyc[b0+4] + 1);
        chk("model_cnt1",  m_cnt, 16'd1);
        chk("model_snap1", m_snap, 64'h10);

        // Held level: exactly one record
        do_reset();
        ack = 1'b1;
        b0 = log_addr.size(); d0 = done_cyc.size();
        upLMT = 1'b1;
        repeat (20) step();
        upLMT = 1'b0;
        repeat (5) step();
        chk("held_words", log_addr.size() - b0, 5);
        chk("held_done",  done_cyc.size() - d0, 1);
        chk("held_cnt_word", log_data[log_data.size()-1], 16'd1);

        // Second rise during word 2: back-to-back records
        do_reset();
        ack = 1'b1;
        repeat (3) step();
        b0 = log_addr.size(); d0 = done_cyc.size(); nb0 = n_busy;
        upLMT = 1'b1; step(); upLMT = 1'b0;
        for (int k = 0; k < 10 && !(m_act && m_pos == 2); k++) step();
        chk("b2b_at_word2", mem_if.lmt_addr, 16'h0044);
        upLMT = 1'b1; step(); upLMT = 1'b0;
        repeat (12) step();
        chk("b2b_words", log_addr.size() - b0, 10);
        chk("b2b_done",  done_cyc.size() - d0, 2);
        chk("b2b_busy",  n_busy - nb0, 10);
        if (log_addr.size() - b0 == 10) begin
            chk("b2b_gap",  log_cyc[b0+9] - log_cyc[b0], 9);
            chk("b2b_cnt1", log_data[b0+4], 16'd1);
            chk("b2b_cnt2", log_data[b0+9], 16'd2);
            chk("b2b_addr2", log_addr[b0+5], 16'h0040);
            s1 = {log_data[b0+3], log_data[b0+2], log_data[b0+1], log_data[b0]};
            s2 = {log_data[b0+8], log_data[b0+7], log_data[b0+6], log_data[b0+5]};
            chk("b2b_later_ts", s2 > s1, 1'b1);
        end

        // Ack timeout
        do_reset();
        ack = 1'b0;
        b0 = log_addr.size(); d0 = done_cyc.size(); nb0 = n_busy;
        upLMT = 1'b1; step(); upLMT = 1'b0;
        repeat (70) step();
        chk("to_err",   err, 1'b1);
        chk("to_busy",  busy, 1'b0);
        chk("to_wcyc",  n_busy - nb0, ACK_TO);
        chk("to_done",  done_cyc.size() - d0, 0);
        chk("to_words", log_addr.size() - b0, 0);
        chk("to_cnt",   m_cnt, 16'd0);
        repeat (10) step();
        chk("to_sticky", err, 1'b1);
        do_reset();
        chk("to_cleared", err, 1'b0);

        // Reset while idx=3, then a fresh record counts from 1
        do_reset();
        ack = 1'b1;
        upLMT = 1'b1; step(); upLMT = 1'b0;
        for (int k = 0; k < 10 && !(m_act && m_pos == 3); k++) step();
        chk("mid_at_idx3", mem_if.lmt_addr, 16'h0046);
        reset = 1'b1; step(); reset = 1'b0;
        chk("mid_wr",   mem_if.lmt_wr, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_ts",   timestamp, 64'd0);
        b0 = log_addr.size();
        upLMT = 1'b1; step(); upLMT = 1'b0;
        repeat (7) step();
        chk("mid_words", log_addr.size() - b0, 5);
        chk("mid_cnt_word", log_data[log_data.size()-1], 16'd1);

        // Randomised traffic against the model
        do_reset();
        mode = 0;
        for (int k = 0; k < 4000; k++) begin
            if (k % 200 == 0) mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) upLMT = ~upLMT;
            case (mode)
                0:       ack = ($urandom_range(0, 1) == 1);
                1:       ack = ($urandom_range(0, 7) != 0);
                default: ack = ($urandom_range(0, 99) == 0);
            endcase
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        reset = 1'b0; ack = 1'b0; upLMT = 1'b0;
        step();

        // Prescaled timer near wrap
        tmr_reset = 1'b1; step(); tmr_reset = 1'b0;
        for (int n = 0; n < 41; n++) begin
            chk("tmr_ts", tmr_ts, TMR_INIT + 64'(n / 4));
            if (n == 12) chk("tmr_wrap0", tmr_ts, 64'd0);
            step();
        end
        chk("tmr_end", tmr_ts, 64'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lmt_writer.md
LMT_WRITER -- requirements
Module: lmt_writer

Interface
REQ-001 SHALL have parameter LMT_BASE, default 16'h0040, meaning the byte address of the first LMT word.
REQ-002 SHALL have parameter TICK_DIV, default 16'd1, meaning the number of clk cycles per timestamp increment (minimum 1).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 16'd64, meaning the maximum number of cycles to wait for lmt_ack per word.
REQ-004 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port upLMT  input  1  update request level from the RATA monitor.
REQ-007 SHALL have port lmt_ack  input  1  memory accepted current word this cycle.
REQ-008 SHALL have port lmt_wr  output  1  word write request, held until acked.
REQ-009 SHALL have port lmt_addr  output  16  byte address of current word.
REQ-010 SHALL have port lmt_wdata  output  16  data of current word.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse on completion of a 5-word record.
REQ-013 SHALL have port err  output  1  sticky ack-timeout flag.
REQ-014 SHALL have port timestamp  output  64  live timestamp counter value.

Function
REQ-015 SHALL increment timestamp by 1 every TICK_DIV clk cycles using a prescaler, with 64-bit modulo wrap from all-ones to zero.
REQ-016 SHALL define trigger as upLMT & ~upLMT_q, where upLMT_q is upLMT registered; a level held high yields exactly one trigger.
REQ-017 SHALL implement states IDLE and WRITE.
REQ-018 SHALL, on a trigger in IDLE, snapshot timestamp into snap, clear idx, and enter WRITE the next cycle.
REQ-019 SHALL, in WRITE, drive lmt_wr=1, lmt_addr=LMT_BASE+2*idx and lmt_wdata = word[idx] combinationally from registered state.
REQ-020 SHALL define word[0..3] as snap[15:0], snap[31:16], snap[47:32] and snap[63:48], and word[4] as upd_cnt+1.
REQ-021 SHALL, on lmt_ack with idx<4, increment idx in the same cycle and reset the timeout counter.
REQ-022 SHALL, on lmt_ack with idx==4, increment upd_cnt (16-bit, wrapping), pulse done for the next cycle, and return to IDLE.
REQ-023 SHALL count WRITE cycles without ack, and when the count reaches ACK_TIMEOUT set err, abort to IDLE, leave upd_cnt unchanged and not pulse done.
REQ-024 SHALL hold lmt_wr=0 and lmt_addr/lmt_wdata=0 in IDLE.
REQ-025 SHALL, on a trigger while in WRITE, set pending; at completion or abort with pending set, go directly to a fresh snapshot and WRITE (no IDLE cycle), then clear pending; further triggers while pending collapse into one.
REQ-026 SHALL ignore lmt_ack in IDLE.
REQ-027 SHALL use only the dedicated lmt_* port for its writes, never the CPU data bus or DMA.

Reset
REQ-028 SHALL, on reset, clear state to IDLE, and clear timestamp, prescaler, snap, idx, upd_cnt, pending, timeout counter, upLMT_q, done and err to 0.
REQ-029 SHALL, on reset asserted mid-record, abandon the record with no further lmt_wr after the reset cycle.

Structure
REQ-030 SHALL place the state encodings, LMT_BASE and the LMT word count (5) in the shared RATA constants file used by the monitor.
REQ-031 SHALL implement the timestamp/prescaler as sub-module lmt_timer (clk, reset, timestamp).

Verification
REQ-032 SHALL verify: reset, then upLMT pulse at timestamp 0x0000_0000_0000_0010 with ack always 1 -> writes to 0x0040/42/44/46/48 with data 0010/0000/0000/0000/0001, done on the cycle after the 0x0048 write, busy for 5 cycles.
REQ-033 SHALL verify: upLMT held high for 20 cycles -> exactly one record is written, and upd_cnt becomes 1.
REQ-034 SHALL verify: a second upLMT rise during word 2 -> the records complete back-to-back, the second carrying a later timestamp and count 2, with no IDLE cycle between them.
REQ-035 SHALL verify: lmt_ack held 0 -> err=1 after 64 WRITE cycles, return to IDLE, no done, and upd_cnt unchanged; err stays 1 until reset.
REQ-036 SHALL verify: TICK_DIV=4 with timestamp preset near 0xFFFF_FFFF_FFFF_FFFF -> increment every 4 cycles and wrap to 0.
REQ-037 SHALL verify: reset asserted while idx=3 -> lmt_wr=0 the next cycle, all state cleared, and a subsequent trigger writes a full record with count 1.
